// File: rtl/tis_link.sv
// tis_link: two independent one-word handshake channels (A->B, B->A) with write saturation
// define TIS_LINK_BYPASS_EN for same-cycle forwarding of a write to the reader
module tis_link_ch #(
  parameter int WIDTH = 11,
  parameter int LIMIT = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic             wready,
  output logic             wack,
  output logic             rready,
  output logic [WIDTH-1:0] rdata
);
  localparam logic [1:0] EMPTY = 2'd0, FULL = 2'd1, ACK = 2'd2;
  localparam logic signed [WIDTH-1:0] PMAX = WIDTH'(LIMIT);
  localparam logic signed [WIDTH-1:0] NMIN = WIDTH'(-LIMIT);
  logic [1:0] st_q, st_d;
  logic [WIDTH-1:0] data_q, data_d, sat;
  logic take, byp;
  always_comb begin
    sat = ($signed(wdata) > PMAX) ? PMAX : ($signed(wdata) < NMIN) ? NMIN : wdata;
    take = (st_q == EMPTY) && wr;
`ifdef TIS_LINK_BYPASS_EN
    byp = take;
`else
    byp = 1'b0;
`endif
    data_d = take ? sat : data_q;
    st_d = (st_q == ACK) ? EMPTY :
           (st_q == FULL) ? (rd ? ACK : FULL) :
           take ? ((byp && rd) ? ACK : FULL) : EMPTY;
    wready = st_q == EMPTY;
    wack = st_q == ACK;
    rready = (st_q == FULL) || byp;
    rdata = byp ? sat : data_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= EMPTY;
      data_q <= '0;
    end else begin
      st_q <= st_d;
      data_q <= data_d;
    end
endmodule

module tis_link #(
  parameter int WIDTH = 11,
  parameter int LIMIT = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_write,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_wready,
  output logic             a_wack,
  input  logic             a_read,
  output logic             a_rready,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_write,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_wready,
  output logic             b_wack,
  input  logic             b_read,
  output logic             b_rready,
  output logic [WIDTH-1:0] b_rdata
);
  tis_link_ch #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_ab (
    .clk(clk), .rst(rst), .wr(a_write), .wdata(a_data), .rd(b_read),
    .wready(a_wready), .wack(a_wack), .rready(b_rready), .rdata(b_rdata)
  );
  tis_link_ch #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_ba (
    .clk(clk), .rst(rst), .wr(b_write), .wdata(b_data), .rd(a_read),
    .wready(b_wready), .wack(b_wack), .rready(a_rready), .rdata(a_rdata)
  );
endmodule

// File: tb/tb_tis_link.sv
// tb_tis_link: directed table plus multi-cycle sequences for tis_link
module tb_tis_link;
  localparam int W = 12;
`ifdef TIS_LINK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic a_write = 0, a_read = 0, b_write = 0, b_read = 0;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic a_wready, a_wack, a_rready, b_wready, b_wack, b_rready;
  logic [W-1:0] a_rdata, b_rdata;
  int total = 0, bad = 0;

  tis_link #(.WIDTH(W), .LIMIT(999)) dut (
    .clk(clk), .rst(rst),
    .a_write(a_write), .a_data(a_data), .a_wready(a_wready), .a_wack(a_wack),
    .a_read(a_read), .a_rready(a_rready), .a_rdata(a_rdata),
    .b_write(b_write), .b_data(b_data), .b_wready(b_wready), .b_wack(b_wack),
    .b_read(b_read), .b_rready(b_rready), .b_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic aw; int ad; logic br; logic bw; int bd; logic ar;
    logic awr; logic awk; logic brr; int brd;
    logic bwr; logic bwk; logic arr; int ard;
  } vec_t;
  vec_t tv[21];

  function automatic vec_t mk(logic aw, int ad, logic br, logic bw, int bd, logic ar,
                              logic awr, logic awk, logic brr, int brd,
                              logic bwr, logic bwk, logic arr, int ard);
    vec_t v;
    v.aw = aw; v.ad = ad; v.br = br; v.bw = bw; v.bd = bd; v.ar = ar;
    v.awr = awr; v.awk = awk; v.brr = brr; v.brd = brd;
    v.bwr = bwr; v.bwk = bwk; v.arr = arr; v.ard = ard;
    return v;
  endfunction

  task automatic chk(string n, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic drive(logic aw, int ad, logic br, logic bw, int bd, logic ar);
    a_write = aw; a_data = W'(ad); b_read = br;
    b_write = bw; b_data = W'(bd); a_read = ar;
  endtask

  function automatic int sb();
    return int'($signed(b_rdata));
  endfunction

  function automatic int sa();
    return int'($signed(a_rdata));
  endfunction

  initial begin
    int lat, xf, wk, last;
    #1;
    chk("rst a_wready", a_wready, 1);
    chk("rst b_wready", b_wready, 1);
    chk("rst a_rready", a_rready, 0);
    chk("rst b_rready", b_rready, 0);
    chk("rst a_wack", a_wack, 0);
    chk("rst b_wack", b_wack, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifndef TIS_LINK_BYPASS_EN
    tv[0]  = mk(1, 5, 1, 0, 0, 0,       1, 0, 0, 0,      1, 0, 0, 0);
    tv[1]  = mk(0, 0, 1, 0, 0, 0,       0, 0, 1, 5,      1, 0, 0, 0);
    tv[2]  = mk(0, 0, 1, 0, 0, 0,       0, 1, 0, 5,      1, 0, 0, 0);
    tv[3]  = mk(1, 1500, 0, 0, 0, 0,    1, 0, 0, 5,      1, 0, 0, 0);
    tv[4]  = mk(0, 0, 0, 0, 0, 0,       0, 0, 1, 999,    1, 0, 0, 0);
    tv[5]  = mk(0, 0, 1, 0, 0, 0,       0, 0, 1, 999,    1, 0, 0, 0);
    tv[6]  = mk(1, -2000, 0, 0, 0, 0,   0, 1, 0, 999,    1, 0, 0, 0);
    tv[7]  = mk(1, -2000, 0, 0, 0, 0,   1, 0, 0, 999,    1, 0, 0, 0);
    tv[8]  = mk(0, 0, 1, 0, 0, 0,       0, 0, 1, -999,   1, 0, 0, 0);
    tv[9]  = mk(0, 0, 0, 0, 0, 0,       0, 1, 0, -999,   1, 0, 0, 0);
    tv[10] = mk(1, 3, 1, 1, -4, 1,      1, 0, 0, -999,   1, 0, 0, 0);
    tv[11] = mk(0, 0, 1, 0, 0, 1,       0, 0, 1, 3,      0, 0, 1, -4);
    tv[12] = mk(0, 0, 0, 0, 0, 0,       0, 1, 0, 3,      0, 1, 0, -4);
    tv[13] = mk(1, -999, 0, 0, 0, 0,    1, 0, 0, 3,      1, 0, 0, -4);
    tv[14] = mk(1, 999, 1, 0, 0, 0,     0, 0, 1, -999,   1, 0, 0, -4);
    tv[15] = mk(0, 0, 1, 0, 0, 0,       0, 1, 0, -999,   1, 0, 0, -4);
    tv[16] = mk(0, 0, 1, 0, 0, 0,       1, 0, 0, -999,   1, 0, 0, -4);
    tv[17] = mk(1, 1000, 0, 0, 0, 0,    1, 0, 0, -999,   1, 0, 0, -4);
    tv[18] = mk(0, 0, 0, 0, 0, 0,       0, 0, 1, 999,    1, 0, 0, -4);
    tv[19] = mk(0, 0, 1, 0, 0, 0,       0, 0, 1, 999,    1, 0, 0, -4);
    tv[20] = mk(0, 0, 0, 0, 0, 0,       0, 1, 0, 999,    1, 0, 0, -4);
    for (int i = 0; i < 21; i++) begin
      drive(tv[i].aw, tv[i].ad, tv[i].br, tv[i].bw, tv[i].bd, tv[i].ar);
      #1;
      chk($sformatf("v%0d a_wready", i), a_wready, tv[i].awr);
      chk($sformatf("v%0d a_wack", i), a_wack, tv[i].awk);
      chk($sformatf("v%0d b_rready", i), b_rready, tv[i].brr);
      chk($sformatf("v%0d b_rdata", i), sb(), tv[i].brd);
      chk($sformatf("v%0d b_wready", i), b_wready, tv[i].bwr);
      chk($sformatf("v%0d b_wack", i), b_wack, tv[i].bwk);
      chk($sformatf("v%0d a_rready", i), a_rready, tv[i].arr);
      chk($sformatf("v%0d a_rdata", i), sa(), tv[i].ard);
      @(negedge clk);
    end
`endif

    // write 5 with B reading continuously: wack latency and single delivery
    drive(1, 5, 1, 0, 0, 0);
    lat = -1; xf = 0;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      #1;
      if (b_rready) begin
        xf++;
        chk("lat b_rdata", sb(), 5);
      end
      if (a_wack) lat = c;
      @(negedge clk);
      a_write = 1'b0;
    end
    chk("lat wack cycles", lat, BYP ? 1 : 2);
    chk("lat transfers", xf, 1);

    // stall: held word 7 survives a second write of 9, which is never delivered
    drive(1, 7, 0, 0, 0, 0);
    #1;
    chk("stall accept", a_wready, 1);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      drive(k >= 3, 9, 0, 0, 0, 0);
      #1;
      chk($sformatf("stall%0d b_rready", k), b_rready, 1);
      chk($sformatf("stall%0d b_rdata", k), sb(), 7);
      chk($sformatf("stall%0d a_wready", k), a_wready, 0);
      @(negedge clk);
    end
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk("stall read rdy", b_rready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("stall wack", a_wack, 1);
    chk("stall ack rready", b_rready, 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("post%0d b_rready", k), b_rready, 0);
      chk($sformatf("post%0d a_wack", k), a_wack, 0);
      chk($sformatf("post%0d b_rdata", k), sb(), 7);
      @(negedge clk);
    end

    // asynchronous reset mid-cycle while FULL discards the word
    drive(1, 42, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("pre-rst b_rready", b_rready, 1);
    chk("pre-rst b_rdata", sb(), 42);
    #2 rst = 1'b1;
    #1;
    chk("arst a_wready", a_wready, 1);
    chk("arst b_rready", b_rready, 0);
    chk("arst a_wack", a_wack, 0);
    chk("arst b_rdata", sb(), 0);
    @(negedge clk);
    #1;
    chk("rst hold a_wack", a_wack, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst rel a_wack", a_wack, 0);
    chk("rst rel b_rready", b_rready, 0);
    chk("rst rel a_wready", a_wready, 1);
    @(negedge clk);

    // back-to-back writes of 100 with B always reading: throughput
    drive(1, 100, 1, 0, 0, 0);
    wk = 0; xf = 0; last = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (a_wack) begin
        wk++;
        if (last >= 0) chk($sformatf("tput gap@%0d", c), c - last, BYP ? 2 : 3);
        last = c;
      end
      if (b_rready) begin
        xf++;
        chk($sformatf("tput data@%0d", c), sb(), 100);
      end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("tput wacks", wk, BYP ? 6 : 4);
    chk("tput transfers", xf, BYP ? 6 : 4);
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tis_link.md
TIS_LINK -- requirements
Module: tis_link

Interface
REQ-001 Parameter WIDTH, default 11, data word width in bits (signed two's complement).
REQ-002 Parameter LIMIT, default 999, saturation magnitude applied to written words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 a_write  input  1  side A offers a_data for transfer A->B.
REQ-006 a_data  input  WIDTH  signed word from side A.
REQ-007 a_wready  output  1  A->B slot empty; a write from A is accepted this cycle.
REQ-008 a_wack  output  1  one-cycle pulse: the word A wrote has been consumed by B.
REQ-009 a_read  input  1  side A consumes the B->A word.
REQ-010 a_rready  output  1  B->A slot holds a word readable by A.
REQ-011 a_rdata  output  WIDTH  B->A word, valid while a_rready is high.
REQ-012 b_write, b_data, b_wready, b_wack, b_read, b_rready, b_rdata shall mirror REQ-005..011 with A and B swapped.

Function
REQ-013 Two independent one-word channels, A->B and B->A, shall be implemented with identical logic; the rules below are stated for A->B.
REQ-014 Channel FSM states: EMPTY, FULL, ACK; reset state EMPTY.
REQ-015 EMPTY: a_wready=1; on a_write, the word is latched and the FSM moves to FULL.
REQ-016 FULL: b_rready=1, b_rdata=latched word, a_wready=0; on b_read the FSM moves to ACK; otherwise it stays in FULL indefinitely.
REQ-017 ACK: a_wack=1 for exactly this cycle, a_wready=0, b_rready=0; next state EMPTY unconditionally.
REQ-018 Latched word = a_data clamped to [-LIMIT, +LIMIT]: +LIMIT if greater, -LIMIT if less, otherwise unchanged.
REQ-019 a_write while in FULL or ACK shall be ignored; the held word and the state are unchanged.
REQ-020 b_read while not b_rready shall be ignored.
REQ-021 a_write and b_read asserted in the same cycle in FULL: the read completes (FULL->ACK) and the write is ignored.
REQ-022 Minimum write-to-wack latency without bypass: write at edge N, b_rready from N+1, read sampled at N+1 at the earliest, a_wack high during cycle N+2, a_wready high again from N+3.
REQ-023 Activity on one channel shall never affect the other channel; simultaneous writes in both directions shall both be accepted.
REQ-024 a_rdata and b_rdata shall hold their last latched value when not ready; consumers shall qualify them with rready.

Reset
REQ-025 rst shall force both channels to EMPTY and clear both held words to 0, independent of clk.
REQ-026 During and immediately after reset: a_wready=b_wready=1, a_rready=b_rready=0, a_wack=b_wack=0.
REQ-027 A word in FULL or ACK when rst asserts shall be discarded with no wack pulse.

Configuration
REQ-028 Macro TIS_LINK_BYPASS_EN shall select same-cycle forwarding.
REQ-029 With TIS_LINK_BYPASS_EN defined, in EMPTY with a_write high: b_rready=1 and b_rdata=clamped a_data combinationally; b_read in that same cycle shall move EMPTY->ACK directly, skipping FULL; without b_read the FSM enters FULL as in REQ-015.
REQ-030 Without TIS_LINK_BYPASS_EN, b_rready shall depend only on registered state, with latency per REQ-022.

Verification
REQ-031 Reset, then A writes 5 with B reading continuously -> b_rdata=5 with b_rready for one cycle; a_wack pulses once, 2 cycles after the write edge (1 cycle with bypass).
REQ-032 A writes 1500, then A writes -2000 after wack -> B reads 999, then -999.
REQ-033 A writes 7, B idle 10 cycles, A writes 9 during the stall -> b_rready stays high with 7, a_wready low; after B reads, a_wack pulses and 9 is never delivered.
REQ-034 A writes 3 and B writes -4 in the same cycle, both sides reading -> B receives 3, A receives -4, both wacks pulse in the same cycle.
REQ-035 A writes 42; rst asserted asynchronously mid-cycle while FULL -> outputs immediately at reset values, no a_wack, b_rdata=0.
REQ-036 Repeated writes of 100 with B reading every cycle, run both with and without TIS_LINK_BYPASS_EN -> one transfer every 3 cycles without bypass, every 2 cycles with bypass.
